// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, funct3 size codes,
// byte-enable width and access-legality helpers.
`ifndef On
`define On 1'b1
`endif
`ifndef Off
`define Off 1'b0
`endif

package load_store_unit_pkg;

  localparam int BE_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  function automatic size_e f3_size(input logic [2:0] f3);
    return size_e'(f3[1:0]);
  endfunction

  // Unsigned variants exist only for loads, and never for words.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    return (f3[1:0] != 2'b11) && (!f3[2] || (!is_store && !f3[1]));
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: return !a[0];
      SZ_WORD: return (a == 2'b00);
      SZ_BYTE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and the data memory
// or interconnect (slave).
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [31:0]     bus_addr;
  logic [BE_W-1:0] bus_be;
  logic [31:0]     bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [31:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_data_align.sv
// Pure combinational lane logic: store byte-enables and data replication,
// plus extraction and sign/zero extension of load data.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      st_funct3_i,
  input  logic [1:0]      st_addr_i,
  input  logic [31:0]     st_wdata_i,
  output logic [BE_W-1:0] st_be_o,
  output logic [31:0]     st_wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_addr_i,
  input  logic [31:0]     ld_rdata_i,
  output logic [31:0]     ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = '1;
    st_wdata_o = st_wdata_i;
    case (f3_size(st_funct3_i))
      SZ_BYTE: begin
        st_be_o    = BE_W'(1) << st_addr_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_addr_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one access in IDLE, issues it on
// the bus in REQ, and waits for read data in WAIT before write-back.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_re_i,
  input  logic                      mem_we_i,
  input  logic [2:0]                funct3_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [4:0]                rd_addr_i,
  output logic                      stall_o,
  output logic [31:0]               rdata_o,
  output logic [4:0]                rd_addr_o,
  output logic                      rd_we_o,
  output logic                      fault_o,
  load_store_unit_if.master         bus
);

  logic [1:0]      state_q, state_d;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [BE_W-1:0] be_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic [4:0]      rd_addr_q;
  logic            rd_we_q, fault_q;

  logic            acc_legal, acc_illegal;
  logic [BE_W-1:0] st_be;
  logic [31:0]     st_wdata, ld_data;

  assign acc_legal = (mem_re_i ^ mem_we_i)
                   && f3_legal(funct3_i, mem_we_i)
                   && is_aligned(f3_size(funct3_i), addr_i[1:0]);
  assign acc_illegal = (mem_re_i || mem_we_i) && !acc_legal;

  lsu_data_align u_align (
    .st_funct3_i (funct3_i),
    .st_addr_i   (addr_i[1:0]),
    .st_wdata_i  (wdata_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (funct3_q),
    .ld_addr_i   (addr_q[1:0]),
    .ld_rdata_i  (bus.bus_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    stall_o = `Off;
    case (state_q)
      S_IDLE: begin
        stall_o = acc_legal;
        if (acc_legal) state_d = S_REQ;
      end
      S_REQ: begin
        stall_o = !(bus.bus_gnt && we_q);
        if (bus.bus_gnt) state_d = we_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = !bus.bus_rvalid;
        if (bus.bus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset is asynchronous, so the combinational hold must also clear at once.
    if (rst_i) stall_o = `Off;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      funct3_q  <= '0;
      we_q      <= `Off;
      rd_addr_q <= '0;
      rd_we_q   <= `Off;
      fault_q   <= `Off;
    end else begin
      state_q <= state_d;
      rd_we_q <= `Off;
      fault_q <= (state_q == S_IDLE) && acc_illegal;
      if (state_q == S_IDLE && acc_legal) begin
        addr_q    <= addr_i;
        wdata_q   <= st_wdata;
        be_q      <= st_be;
        funct3_q  <= funct3_i;
        we_q      <= mem_we_i;
        rd_addr_q <= rd_addr_i;
      end
      if (state_q == S_WAIT && bus.bus_rvalid) begin
        rdata_q <= ld_data;
        rd_we_q <= `On;
      end
    end
  end

  assign bus.bus_req   = (state_q == S_REQ);
  assign bus.bus_we    = (state_q == S_REQ) && we_q;
  assign bus.bus_be    = (state_q == S_REQ) ? be_q : '0;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_wdata = wdata_q;

  assign rdata_o   = rdata_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_we_o   = rd_we_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads with extension, delayed-grant
// stores, illegal accesses and reset in the middle of a load.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        fault_o;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit_if bif ();

  load_store_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .mem_re_i  (mem_re_i),
    .mem_we_i  (mem_we_i),
    .funct3_i  (funct3_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rd_addr_i (rd_addr_i),
    .stall_o   (stall_o),
    .rdata_o   (rdata_o),
    .rd_addr_o (rd_addr_o),
    .rd_we_o   (rd_we_o),
    .fault_o   (fault_o),
    .bus       (bif.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Load with best-case timing: grant in cycle 1, read data in cycle 2.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] bdata,
                         input logic [31:0] exp);
    step();
    mem_re_i = 1'b1; funct3_i = f3; addr_i = a; rd_addr_i = rd;
    #1 chk({tag, "_c0_stall"}, 32'(stall_o), 32'd1);
    step();
    bif.bus_gnt = 1'b1;
    #1 chk({tag, "_c1_req"}, 32'(bif.bus_req), 32'd1);
    chk({tag, "_c1_addr"}, bif.bus_addr, {a[31:2], 2'b00});
    chk({tag, "_c1_stall"}, 32'(stall_o), 32'd1);
    step();
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = bdata;
    #1 chk({tag, "_c2_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_c2_req"}, 32'(bif.bus_req), 32'd0);
    step();
    mem_re_i = 1'b0; bif.bus_rvalid = 1'b0;
    #1 chk({tag, "_c3_rdwe"}, 32'(rd_we_o), 32'd1);
    chk({tag, "_c3_rdata"}, rdata_o, exp);
    chk({tag, "_c3_rd"}, 32'(rd_addr_o), 32'(rd));
    step();
    chk({tag, "_c4_rdwe"}, 32'(rd_we_o), 32'd0);
  endtask

  initial begin
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;

    // Reset state
    #1 rst_i = 1'b1;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(bif.bus_req), 32'd0);
    chk("rst_we", 32'(bif.bus_we), 32'd0);
    chk("rst_be", 32'(bif.bus_be), 32'd0);
    chk("rst_addr", bif.bus_addr, 32'd0);
    chk("rst_wdata", bif.bus_wdata, 32'd0);
    chk("rst_rdwe", 32'(rd_we_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    step(); step();
    rst_i = 1'b0;

    // Loads: word, signed/unsigned byte and halfword lanes
    do_load("lw100", F3_W, 32'h100, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb103", F3_B, 32'h103, 5'd6, 32'h80FF_0000, 32'hFFFFFF80);
    do_load("lbu103", F3_BU, 32'h103, 5'd7, 32'h80FF_0000, 32'h00000080);
    do_load("lh102", F3_H, 32'h102, 5'd8, 32'h80FF_0000, 32'hFFFF80FF);
    do_load("lhu100", F3_HU, 32'h100, 5'd9, 32'h1234_F00D, 32'h0000F00D);
    do_load("lb101", F3_B, 32'h101, 5'd10, 32'h0000_7F00, 32'h0000007F);

    // SH with grant delayed by three cycles; bus fields must hold
    step();
    mem_we_i = 1'b1; funct3_i = F3_H; addr_i = 32'h202; wdata_i = 32'h0000ABCD;
    #1 chk("sh_c0_stall", 32'(stall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sh_hold_req", 32'(bif.bus_req), 32'd1);
      chk("sh_hold_be", 32'(bif.bus_be), 32'b1100);
      chk("sh_hold_wdata", bif.bus_wdata, 32'hABCDABCD);
      chk("sh_hold_addr", bif.bus_addr, 32'h200);
      chk("sh_hold_stall", 32'(stall_o), 32'd1);
    end
    step();
    bif.bus_gnt = 1'b1;
    #1 chk("sh_gnt_req", 32'(bif.bus_req), 32'd1);
    chk("sh_gnt_we", 32'(bif.bus_we), 32'd1);
    chk("sh_gnt_stall", 32'(stall_o), 32'd0);
    step();
    mem_we_i = 1'b0; bif.bus_gnt = 1'b0;
    #1 chk("sh_done_req", 32'(bif.bus_req), 32'd0);
    chk("sh_done_be", 32'(bif.bus_be), 32'd0);
    chk("sh_done_stall", 32'(stall_o), 32'd0);

    // SB with immediate grant, then SW accepted in the very next cycle
    step();
    mem_we_i = 1'b1; funct3_i = F3_B; addr_i = 32'h101; wdata_i = 32'h1234565A;
    #1 chk("sb_c0_stall", 32'(stall_o), 32'd1);
    step();
    bif.bus_gnt = 1'b1;
    #1 chk("sb_be", 32'(bif.bus_be), 32'b0010);
    chk("sb_wdata", bif.bus_wdata, 32'h5A5A5A5A);
    chk("sb_addr", bif.bus_addr, 32'h100);
    chk("sb_stall", 32'(stall_o), 32'd0);
    step();
    bif.bus_gnt = 1'b0; funct3_i = F3_W; addr_i = 32'h300; wdata_i = 32'hCAFEF00D;
    #1 chk("sw_c0_stall", 32'(stall_o), 32'd1);
    chk("sw_c0_req", 32'(bif.bus_req), 32'd0);
    step();
    bif.bus_gnt = 1'b1;
    #1 chk("sw_addr", bif.bus_addr, 32'h300);
    chk("sw_be", 32'(bif.bus_be), 32'hF);
    chk("sw_wdata", bif.bus_wdata, 32'hCAFEF00D);
    step();
    mem_we_i = 1'b0; bif.bus_gnt = 1'b0;
    #1 chk("sw_done_req", 32'(bif.bus_req), 32'd0);

    // Misaligned LW
    step();
    mem_re_i = 1'b1; funct3_i = F3_W; addr_i = 32'h101;
    #1 chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_fault_now", 32'(fault_o), 32'd0);
    step();
    mem_re_i = 1'b0;
    #1 chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_req", 32'(bif.bus_req), 32'd0);
    step();
    chk("mis_fault_end", 32'(fault_o), 32'd0);

    // Load and store both requested
    mem_re_i = 1'b1; mem_we_i = 1'b1; funct3_i = F3_B; addr_i = 32'h0;
    #1 chk("both_stall", 32'(stall_o), 32'd0);
    step();
    mem_re_i = 1'b0; mem_we_i = 1'b0;
    #1 chk("both_fault", 32'(fault_o), 32'd1);
    chk("both_req", 32'(bif.bus_req), 32'd0);

    // Unsigned size code is illegal for stores; misaligned LH too
    step();
    mem_we_i = 1'b1; funct3_i = F3_BU; addr_i = 32'h10;
    #1 chk("sbu_stall", 32'(stall_o), 32'd0);
    step();
    mem_we_i = 1'b0;
    #1 chk("sbu_fault", 32'(fault_o), 32'd1);
    step();
    mem_re_i = 1'b1; funct3_i = F3_H; addr_i = 32'h103;
    step();
    mem_re_i = 1'b0;
    #1 chk("lhmis_fault", 32'(fault_o), 32'd1);
    chk("lhmis_req", 32'(bif.bus_req), 32'd0);

    // Stray rvalid and gnt in IDLE are ignored
    step();
    bif.bus_rvalid = 1'b1; bif.bus_gnt = 1'b1; bif.bus_rdata = 32'h55555555;
    step();
    bif.bus_rvalid = 1'b0; bif.bus_gnt = 1'b0;
    #1 chk("stray_rdwe", 32'(rd_we_o), 32'd0);
    chk("stray_req", 32'(bif.bus_req), 32'd0);

    // Reset while waiting for read data
    step();
    mem_re_i = 1'b1; funct3_i = F3_W; addr_i = 32'h400; rd_addr_i = 5'd9;
    step();
    bif.bus_gnt = 1'b1;
    step();
    bif.bus_gnt = 1'b0;
    #1 chk("wrst_wait_stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    #1 chk("wrst_stall", 32'(stall_o), 32'd0);
    chk("wrst_req", 32'(bif.bus_req), 32'd0);
    chk("wrst_addr", bif.bus_addr, 32'd0);
    chk("wrst_rdwe", 32'(rd_we_o), 32'd0);
    chk("wrst_state", 32'(dut.state_q), 32'(S_IDLE));
    step();
    rst_i = 1'b0; mem_re_i = 1'b0;
    step();
    bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h11111111;
    step();
    bif.bus_rvalid = 1'b0;
    #1 chk("wrst_stale_rdwe", 32'(rd_we_o), 32'd0);
    chk("wrst_stale_rdata", rdata_o, 32'd0);
    chk("wrst_stale_state", 32'(dut.state_q), 32'(S_IDLE));

    // Normal operation resumes after the aborted load
    do_load("lw_after", F3_W, 32'h104, 5'd3, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk_i  in  1  single clock; all state changes on rising edge.
REQ-002 rst_i  in  1  asynchronous, active-high reset.
REQ-003 mem_re_i  in  1  load request from decode/execute; held stable while stall_o=1.
REQ-004 mem_we_i  in  1  store request; held stable while stall_o=1.
REQ-005 funct3_i  in  3  access size/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-006 addr_i  in  32  byte address; wdata_i  in  32  store data, low bits significant; rd_addr_i  in  5  load destination.
REQ-007 stall_o  out  1  pipeline hold while an access is accepted or in flight.
REQ-008 rdata_o  out  32  extended load result; rd_addr_o  out  5; rd_we_o  out  1  one-cycle write-back pulse.
REQ-009 fault_o  out  1  one-cycle pulse: misaligned address, illegal funct3, or mem_re_i and mem_we_i both high.
REQ-010 bus_req_o  out  1, bus_we_o  out  1, bus_addr_o  out  32 (bits[1:0]=00), bus_be_o  out  4, bus_wdata_o  out  32.
REQ-011 bus_gnt_i  in  1  request accepted; bus_rvalid_i  in  1  read data valid; bus_rdata_i  in  32.

Function
REQ-012 FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-013 IDLE: exactly one of mem_re_i/mem_we_i high, legal funct3, aligned -> latch address, be, wdata, load/store type, rd_addr; go to REQ.
REQ-014 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; byte always aligned.
REQ-015 Illegal access in IDLE -> no bus activity, no stall, fault_o=1 the following cycle, stay IDLE.
REQ-016 REQ: bus_req_o=1 with latched bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o held constant until bus_gnt_i=1.
REQ-017 REQ with bus_gnt_i=1: store -> IDLE; load -> WAIT.
REQ-018 WAIT: bus_req_o=0; on bus_rvalid_i=1 -> register extended data, go IDLE; rd_we_o=1 and rdata_o valid in the next cycle only.
REQ-019 stall_o = (IDLE and legal access) or (REQ and not (gnt and store)) or (WAIT and not rvalid); combinational, so stall_o drops in the completion cycle.
REQ-020 Store lanes: SB be=1<<addr[1:0], byte replicated in all 4 lanes; SH be=0011 if addr[1]=0 else 1100, halfword replicated; SW be=1111.
REQ-021 Load extract: LB/LBU byte lane addr[1:0]; LH/LHU halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 bus_rvalid_i outside WAIT and bus_gnt_i outside REQ are ignored.
REQ-023 Best-case latency: load 3 cycles from acceptance to rd_we_o (gnt in REQ, rvalid next cycle); store 2 cycles to the next acceptance.
REQ-024 No new access is accepted outside IDLE; one outstanding transaction maximum.

Reset
REQ-025 rst_i asserted: state IDLE; stall_o, bus_req_o, bus_we_o, rd_we_o and fault_o are 0; bus_be_o=0; address, data and rd registers are 0.
REQ-026 Reset mid-transaction aborts it; bus_req_o drops immediately; no rd_we_o pulse; a later stale bus_rvalid_i is ignored.

Structure
REQ-027 The shared package holds the state encoding, the funct3 size constants and the byte-enable width; it reuses the existing On/Off macros.
REQ-028 One combinational sub-module, lsu_data_align, performs store lane replication, byte-enable generation and load extraction.

Verification
REQ-029 LW at addr 0x100, gnt in cycle 1, rvalid with data 0xDEADBEEF in cycle 2 -> rd_we_o=1, rdata_o=0xDEADBEEF in cycle 3; stall_o high in cycles 0-1 only.
REQ-030 LB at addr 0x103, rdata 0x80FF_0000 -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-031 SH at addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles -> bus_be_o=1100, bus_wdata_o=0xABCDABCD, bus_addr_o=0x200, all held until gnt.
REQ-032 LW at addr 0x101 -> no bus_req_o, stall_o=0, fault_o pulse next cycle; mem_re_i and mem_we_i both high -> fault_o pulse.
REQ-033 rst_i asserted in WAIT, rvalid 2 cycles later -> all outputs 0 immediately, no rd_we_o pulse, FSM in IDLE.
